// File: rtl/regfile_dump_streamer.sv
// regfile_dump_streamer
//   Debug read-out engine on one read port of the 32x32 register file. A start
//   pulse walks registers FIRST_REG..LAST_REG. Each word is read once, in READ,
//   and then sent as four little-endian bytes on a valid/ready byte stream.
//   From start until done the engine owns rd_addr.
// Ports
//   clk        in   1   clock, posedge
//   rst        in   1   synchronous active-high reset (aborts a dump at once)
//   start      in   1   begin a dump; only looked at in IDLE
//   busy       out  1   state != IDLE
//   done       out  1   one-cycle pulse after the last byte is accepted
//   rd_addr    out  5   regfile read address
//   rd_data    in   32  regfile read data, combinational from rd_addr
//   out_data   out  8   current byte
//   out_valid  out  1   out_data valid
//   out_ready  in   1   downstream takes the byte when out_valid && out_ready
module regfile_dump_streamer #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  if (!(FIRST_REG >= 0 && FIRST_REG <= LAST_REG && LAST_REG <= 31)) begin : g_bad_range
    $error("regfile_dump_streamer: need 0 <= FIRST_REG <= LAST_REG <= 31");
  end

  localparam logic [4:0] FIRST_A = 5'(FIRST_REG);
  localparam logic [4:0] LAST_A  = 5'(LAST_REG);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_SEND, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_idx, w_idx_nxt;
  logic [4:0]  r_rd_addr, w_rd_addr_nxt;
  logic [31:0] r_shift, w_shift_nxt;
  logic [1:0]  r_byte_cnt, w_byte_cnt_nxt;
  logic [7:0]  r_out_data, w_out_data_nxt;
  logic        r_out_valid, w_out_valid_nxt;
  logic        r_done, w_done_nxt;
  logic        w_accept;

  assign w_accept = r_out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_rd_addr   <= '0;
      r_shift     <= '0;
      r_byte_cnt  <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_rd_addr   <= w_rd_addr_nxt;
      r_shift     <= w_shift_nxt;
      r_byte_cnt  <= w_byte_cnt_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_rd_addr_nxt   = r_rd_addr;
    w_shift_nxt     = r_shift;
    w_byte_cnt_nxt  = r_byte_cnt;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    w_done_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_out_valid_nxt = 1'b0;
        if (start) begin
          w_idx_nxt     = FIRST_A;
          w_rd_addr_nxt = FIRST_A;
          w_state_nxt   = S_READ;
        end
      end
      S_READ: begin
        // Word is captured here only; later regfile writes to it are not seen.
        w_shift_nxt     = rd_data;
        w_out_data_nxt  = rd_data[7:0];
        w_byte_cnt_nxt  = 2'd0;
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = S_SEND;
      end
      S_SEND: begin
        // Without a handshake nothing moves, so the byte is held stable.
        if (w_accept) begin
          w_shift_nxt    = {8'h00, r_shift[31:8]};
          w_out_data_nxt = r_shift[15:8];
          w_byte_cnt_nxt = r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'd3) begin
            w_out_valid_nxt = 1'b0;
            if (r_idx == LAST_A) begin
              w_state_nxt = S_DONE;
              w_done_nxt  = 1'b1;
            end else begin
              // idx stops at LAST_REG, so the +1 never wraps past 31.
              w_idx_nxt     = r_idx + 5'd1;
              w_rd_addr_nxt = r_idx + 5'd1;
              w_state_nxt   = S_READ;
            end
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign rd_addr   = r_rd_addr;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_regfile_dump_streamer.sv
// Bench for regfile_dump_streamer: a model regfile feeds two instances
// (registers 1..2 and the full default range). Expected bytes are queued when a
// dump is set up and popped by negedge monitors on every accepted byte.
module tb_regfile_dump_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic [31:0] regs [32];

  // instance A: FIRST=1, LAST=2
  logic a_start = 1'b0, a_ready = 1'b0, a_busy, a_done, a_valid;
  logic [4:0] a_rd_addr;
  logic [31:0] a_rd_data;
  logic [7:0] a_data;
  // instance B: defaults 0..31
  logic b_start = 1'b0, b_ready = 1'b1, b_busy, b_done, b_valid;
  logic [4:0] b_rd_addr;
  logic [31:0] b_rd_data;
  logic [7:0] b_data;

  assign a_rd_data = (a_rd_addr == 5'd0) ? 32'h0 : regs[a_rd_addr];
  assign b_rd_data = (b_rd_addr == 5'd0) ? 32'h0 : regs[b_rd_addr];

  regfile_dump_streamer #(.FIRST_REG(1), .LAST_REG(2)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data), .out_data(a_data),
    .out_valid(a_valid), .out_ready(a_ready));

  regfile_dump_streamer u_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .out_data(b_data),
    .out_valid(b_valid), .out_ready(b_ready));

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  logic [7:0] qa[$], qb[$];
  int a_bytes = 0, a_dones = 0, b_bytes = 0, b_dones = 0;
  logic rand_rdy = 1'b0;
  logic a_stall = 1'b0;
  logic [7:0] a_prev = 8'h0;

  task automatic push_word(input logic [31:0] w, input bit to_b);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] bt;
      bt = w[8*k +: 8];
      if (to_b) qb.push_back(bt); else qa.push_back(bt);
    end
  endtask

  // monitors: inputs change #1 after posedge, so negedge sees the handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (a_stall) begin
        chk("hold_data", {24'h0, a_data}, {24'h0, a_prev});
        chk("hold_valid", {31'h0, a_valid}, 32'h1);
      end
      a_stall = a_valid && !a_ready;
      a_prev  = a_data;
      if (a_valid && a_ready) begin
        a_bytes++;
        if (qa.size() == 0) chk("a_extra_byte", {24'h0, a_data}, 32'hFFFF_FFFF);
        else chk("a_byte", {24'h0, a_data}, {24'h0, qa.pop_front()});
      end
      if (a_done) a_dones++;
      if (b_valid && b_ready) begin
        b_bytes++;
        if (qb.size() == 0) chk("b_extra_byte", {24'h0, b_data}, 32'hFFFF_FFFF);
        else chk("b_byte", {24'h0, b_data}, {24'h0, qb.pop_front()});
      end
      if (b_done) b_dones++;
    end else begin
      a_stall = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) a_ready = ($urandom_range(0, 1) == 1);
  end

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  // returns in the READ cycle (one cycle after start was sampled)
  task automatic pulse_a;
    @(posedge clk); #1;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  task automatic wait_done_a(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (a_done) break;
      @(posedge clk); #1;
    end
    if (k == budget) chk("a_done_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    int c, b, d0, n0;
    for (int k = 0; k < 32; k++) regs[k] = $urandom;
    regs[0] = 32'hFFFF_FFFF;
    regs[1] = 32'h1122_3344;
    regs[2] = 32'hA5A5_0001;

    // reset state
    step(3);
    chk("rst_busy", {31'h0, a_busy}, 32'h0);
    chk("rst_valid", {31'h0, a_valid}, 32'h0);
    chk("rst_done", {31'h0, a_done}, 32'h0);
    chk("rst_addr", {27'h0, a_rd_addr}, 32'h0);
    chk("rst_data", {24'h0, a_data}, 32'h0);
    rst = 1'b0;
    step(1);

    // 1: x1,x2 with ready high; latency and done timing
    push_word(regs[1], 0); push_word(regs[2], 0);
    a_ready = 1'b1;
    pulse_a();
    chk("t1_busy_read", {31'h0, a_busy}, 32'h1);
    chk("t1_valid_read", {31'h0, a_valid}, 32'h0);
    chk("t1_addr_read", {27'h0, a_rd_addr}, 32'd1);
    step(1);
    chk("t1_first_valid", {31'h0, a_valid}, 32'h1);
    chk("t1_first_byte", {24'h0, a_data}, 32'h44);
    c = 1;
    for (int k = 0; k < 50 && !a_done; k++) begin
      step(1); c++;
    end
    chk("t1_done_lat", c, 32'd10);
    step(1);
    chk("t1_done_pulse", {31'h0, a_done}, 32'h0);
    chk("t1_idle", {31'h0, a_busy}, 32'h0);
    chk("t1_q_empty", qa.size(), 32'h0);
    chk("t1_bytes", a_bytes, 32'd8);

    // 2: full default dump on instance B
    for (int k = 0; k < 32; k++) push_word((k == 0) ? 32'h0 : regs[k], 1);
    @(posedge clk); #1;
    b_start = 1'b1;
    chk("t2_busy_at_start", {31'h0, b_busy}, 32'h0);
    @(posedge clk); #1;
    b_start = 1'b0;
    b = 0;
    for (int k = 0; k < 400; k++) begin
      if (b_busy) b++;
      if (b_done) break;
      step(1);
    end
    chk("t2_busy_cycles", b, 32'd161);
    step(5);
    chk("t2_busy_after", {31'h0, b_busy}, 32'h0);
    chk("t2_bytes", b_bytes, 32'd128);
    chk("t2_dones", b_dones, 32'd1);
    chk("t2_q_empty", qb.size(), 32'h0);

    // 3: random backpressure, same sequence as case 1
    push_word(regs[1], 0); push_word(regs[2], 0);
    n0 = a_bytes;
    rand_rdy = 1'b1;
    pulse_a();
    wait_done_a(400);
    rand_rdy = 1'b0;
    step(1);
    a_ready = 1'b1;
    step(2);
    chk("t3_bytes", a_bytes - n0, 32'd8);
    chk("t3_q_empty", qa.size(), 32'h0);

    // 4: start again mid-SEND and in DONE
    push_word(regs[1], 0); push_word(regs[2], 0);
    n0 = a_bytes; d0 = a_dones;
    pulse_a();
    step(3);
    a_start = 1'b1;
    step(1);
    a_start = 1'b0;
    wait_done_a(100);
    a_start = 1'b1;
    step(1);
    a_start = 1'b0;
    step(20);
    chk("t4_bytes", a_bytes - n0, 32'd8);
    chk("t4_dones", a_dones - d0, 32'd1);
    chk("t4_idle", {31'h0, a_busy}, 32'h0);
    chk("t4_q_empty", qa.size(), 32'h0);

    // 5: reset during the third byte of x1
    qa.push_back(8'h44); qa.push_back(8'h33);
    pulse_a();
    step(3);
    chk("t5_third_byte", {24'h0, a_data}, 32'h22);
    a_ready = 1'b0;
    rst = 1'b1;
    step(1);
    chk("t5_rst_valid", {31'h0, a_valid}, 32'h0);
    chk("t5_rst_busy", {31'h0, a_busy}, 32'h0);
    chk("t5_rst_addr", {27'h0, a_rd_addr}, 32'h0);
    rst = 1'b0;
    a_ready = 1'b1;
    step(3);
    chk("t5_no_more_bytes", {31'h0, a_valid}, 32'h0);
    chk("t5_q_empty", qa.size(), 32'h0);
    push_word(regs[1], 0); push_word(regs[2], 0);
    pulse_a();
    chk("t5_restart_addr", {27'h0, a_rd_addr}, 32'd1);
    wait_done_a(100);
    step(2);
    chk("t5_restart_q_empty", qa.size(), 32'h0);

    // 6: regfile writes while x1 is in SEND
    push_word(32'h1122_3344, 0); push_word(32'hDEAD_BEEF, 0);
    pulse_a();
    step(1);
    regs[1] = 32'hCAFE_F00D;
    regs[2] = 32'hDEAD_BEEF;
    wait_done_a(100);
    step(2);
    chk("t6_q_empty", qa.size(), 32'h0);
    chk("t6_idle", {31'h0, a_busy}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
